// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle restoring divider and sequencer for the EX stage.
// Produces {remainder, quotient} for the HI/LO write and a one-cycle ready
// pulse. Holds the pipeline stalled while iterating; a flush cancels the op.
// Optional build macro: DIV_EARLY_OUT_EN (finish after one BUSY cycle when
// |dividend| < |divisor|, since the quotient is then known to be zero).
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               stall,
  output logic               ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder (magnitude)
  logic [WIDTH-1:0]   quo_q, quo_d;     // dividend shifting out / quotient in
  logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH-1:0]   dvd_q, dvd_d;     // original dividend, sign intact
  logic               qneg_q, qneg_d;   // quotient must be negated
  logic               rneg_q, rneg_d;   // remainder must be negated
  logic               early_q, early_d; // result known after one BUSY cycle
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               accept_s;
  logic               a_neg_s, b_neg_s, early_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     r_sh_s, diff_s;
  logic [WIDTH-1:0]   rem_step_s, quo_step_s, rem_fin_s, quo_fin_s;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Operand magnitudes, one restoring step and the sign-corrected final result.
  always_comb begin
    accept_s = (state_q == IDLE) && start && !flush;
    a_neg_s  = signed_div & opa[WIDTH-1];
    b_neg_s  = signed_div & opb[WIDTH-1];
    a_mag_s  = a_neg_s ? twos_neg(opa) : opa;
    b_mag_s  = b_neg_s ? twos_neg(opb) : opb;
`ifdef DIV_EARLY_OUT_EN
    early_s  = (opb != {WIDTH{1'b0}}) && (a_mag_s < b_mag_s);
`else
    early_s  = 1'b0;
`endif
    r_sh_s     = {rem_q, quo_q[WIDTH-1]};
    diff_s     = r_sh_s - {1'b0, dvs_q};
    rem_step_s = diff_s[WIDTH] ? r_sh_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
    quo_step_s = {quo_q[WIDTH-2:0], ~diff_s[WIDTH]};
    quo_fin_s  = qneg_q ? twos_neg(quo_step_s) : quo_step_s;
    rem_fin_s  = rneg_q ? twos_neg(rem_step_s) : rem_step_s;
  end

  // Next-state logic: accept, iterate, present result, flush cancel.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    dvd_d    = dvd_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    early_d  = early_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          dvd_d   = opa;
          dvs_d   = b_mag_s;
          rem_d   = {WIDTH{1'b0}};
          quo_d   = a_mag_s;
          qneg_d  = a_neg_s ^ b_neg_s;
          rneg_d  = a_neg_s;
          early_d = early_s;
          cnt_d   = 6'd0;
          if (opb == {WIDTH{1'b0}}) begin
            // Divide by zero needs no iteration.
            state_d  = DONE;
            result_d = {opa, {WIDTH{1'b1}}};
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (early_q) begin
          state_d  = DONE;
          result_d = {dvd_q, {WIDTH{1'b0}}};
        end else begin
          rem_d = rem_step_s;
          quo_d = quo_step_s;
          if (cnt_q == LAST_STEP) begin
            state_d  = DONE;
            result_d = {rem_fin_s, quo_fin_s};
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      DONE: begin
        // start is ignored here: the same instruction is still in E.
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = 6'd0;
      result_d = result_q;
    end else begin
      state_d = state_d;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      rem_q    <= {WIDTH{1'b0}};
      quo_q    <= {WIDTH{1'b0}};
      dvs_q    <= {WIDTH{1'b0}};
      dvd_q    <= {WIDTH{1'b0}};
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      early_q  <= 1'b0;
      result_q <= {(2*WIDTH){1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      dvd_q    <= dvd_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      early_q  <= early_d;
      result_q <= result_d;
    end
  end

  // Stall covers the accept cycle and iteration; reset or flush drop it at once.
  assign stall  = reset && !flush && ((state_q == BUSY) || accept_s);
  assign ready  = (state_q == DONE);
  assign busy   = (state_q != IDLE);
  assign result = result_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: stimulus pushes expected results into a
// queue; a negedge monitor pops and compares whenever ready is seen.
module tb_div_seq_ctrl;
  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic           clk = 1'b0;
  logic           reset, flush, start, signed_div;
  logic [W-1:0]   opa, opb;
  logic           stall, ready, busy;
  logic [2*W-1:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = 64'd0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .start(start),
    .signed_div(signed_div), .opa(opa), .opb(opb),
    .stall(stall), .ready(ready), .result(result), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_ready", {63'd0, ready}, 64'd0);
      else                   chk("result", result, exp_q.pop_front());
    end
  end

  // Issue one op, hold start until ready, check latency, stall length, no re-accept.
  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [63:0] exp, input int exp_lat);
    int lat = -1;
    int stl = 0;
    @(posedge clk); #1;
    opa = a; opb = b; signed_div = s; start = 1'b1;
    exp_q.push_back(exp);
    for (int k = 0; k < 60 && lat < 0; k++) begin
      @(negedge clk);
      if (stall === 1'b1) stl++;
      if (ready === 1'b1) lat = k;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({nm, "_ready_cycle"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_stall_cycles"}, 64'(stl), 64'(exp_lat));
    @(negedge clk);
    chk({nm, "_no_reaccept"}, {63'd0, busy}, 64'd0);
    last_res = exp;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; start = 1'b0; signed_div = 1'b0;
    opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall",  {63'd0, stall}, 64'd0);
    chk("rst_ready",  {63'd0, ready}, 64'd0);
    chk("rst_busy",   {63'd0, busy},  64'd0);
    chk("rst_result", result, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_op("divu_100_7",  32'd100,        32'd7,          1'b0, {32'd2, 32'd14},                  33);
    run_op("div_m7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD},   33);
    run_op("div_7_m2",    32'd7,          32'hFFFF_FFFE,  1'b1, {32'd1, 32'hFFFF_FFFD},           33);
    run_op("div_min_m1",  32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'd0, 32'h8000_0000},           33);
    run_op("divu_big",    32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, {32'd1, 32'd1},                   33);
    run_op("divu_5_0",    32'd5,          32'd0,          1'b0, {32'd5, 32'hFFFF_FFFF},           1);
    run_op("div_m5_0",    32'hFFFF_FFFB,  32'd0,          1'b1, {32'hFFFF_FFFB, 32'hFFFF_FFFF},   1);
    run_op("divu_3_9",    32'd3,          32'd9,          1'b0, {32'd3, 32'd0},                   EARLY_LAT);
    run_op("div_m1_m2",   32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b1, {32'hFFFF_FFFF, 32'd0},           EARLY_LAT);

    // Flush at T10 of a 100/7 op, then a fresh op at T12.
    @(posedge clk); #1;
    opa = 32'd100; opb = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("flush_stall_t10", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_t11", {63'd0, busy}, 64'd0);
    chk("flush_result_held", result, last_res);
    run_op("after_flush", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);

    // Reset at T15 of an op: outputs clear immediately, no ready pulse.
    @(posedge clk); #1;
    opa = 32'd100; opb = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("midrst_stall",  {63'd0, stall}, 64'd0);
    chk("midrst_ready",  {63'd0, ready}, 64'd0);
    chk("midrst_busy",   {63'd0, busy},  64'd0);
    chk("midrst_result", result, 64'd0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_op("after_reset", 32'd1000, 32'd10, 1'b0, {32'd0, 32'd100}, 33);

    repeat (5) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
